// File: rtl/iter_divider_pkg.sv
//==============================================================================
// Module      : iter_divider_pkg
// Description : Shared types, widths and extension helpers for iter_divider.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package iter_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_XLEN = 64;
    localparam int DIV_WLEN = 32;

    // Keep the low w bits of v; above them copy bit w-1 (sgn=1) or clear (sgn=0).
    function automatic logic [DIV_XLEN-1:0] div_ext(
        input logic [DIV_XLEN-1:0] v,
        input int                  w,
        input logic                sgn
    );
        logic [DIV_XLEN-1:0] hi;
        logic [DIV_XLEN-1:0] sh;
        hi = {DIV_XLEN{1'b1}} << w;
        sh = v >> (w - 1);
        if (sgn && sh[0])
            return v | hi;
        else
            return v & ~hi;
    endfunction

    function automatic logic [DIV_XLEN-1:0] div_mag(
        input logic [DIV_XLEN-1:0] v,
        input logic                neg
    );
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iter_divider_if.sv
//==============================================================================
// Module      : iter_divider_if
// Description : valid/data_ok request bundle between the ALU and the divider.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface iter_divider_if
    import iter_divider_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) ();
    logic            valid;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            is_signed;
    logic            word;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
    logic            data_ok;

    modport master (
        output valid, a, b, is_signed, word,
        input  quot, rem, data_ok
    );

    modport slave (
        input  valid, a, b, is_signed, word,
        output quot, rem, data_ok
    );
endinterface

`default_nettype wire

// File: rtl/iter_divider_div_step.sv
//==============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration on magnitudes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_step
    import iter_divider_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  wire logic [XLEN-1:0] i_rem,
    input  wire logic            i_qin,
    input  wire logic [XLEN-1:0] i_div,
    output logic      [XLEN-1:0] o_rem,
    output logic                 o_qbit
);
    // One extra bit: the shifted remainder can reach 2*divisor-1.
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    assign w_shift = {i_rem, i_qin};
    assign w_diff  = w_shift - {1'b0, i_div};
    assign o_qbit  = ~w_diff[XLEN];
    assign o_rem   = o_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
endmodule

`default_nettype wire

// File: rtl/iter_divider.sv
//==============================================================================
// Module      : iter_divider
// Description : Multi-cycle radix-2 restoring divider, RISC-V DIV/REM(U)(W).
//               DIV_EARLY_OUT_EN: finish at once when |a| < |b|.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  wire logic     clk,
    input  wire logic     reset,
    iter_divider_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);

    div_state_t      r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_d;
    logic            r_qneg;
    logic            r_rneg;
    logic            r_word;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic            r_data_ok;

    int              w_width;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_a_res, w_min;
    logic            w_a_neg, w_b_neg, w_div0, w_ovf, w_early;
    logic [XLEN-1:0] w_step_rem, w_q_fix, w_r_fix;
    logic            w_qbit;

    assign w_width = bus.word ? DIV_WLEN : XLEN;
    assign w_a_ext = div_ext(bus.a, w_width, bus.is_signed);
    assign w_b_ext = div_ext(bus.b, w_width, bus.is_signed);
    assign w_a_res = div_ext(bus.a, w_width, 1'b1);
    assign w_a_neg = bus.is_signed & w_a_ext[XLEN-1];
    assign w_b_neg = bus.is_signed & w_b_ext[XLEN-1];
    assign w_a_mag = div_mag(w_a_ext, w_a_neg);
    assign w_b_mag = div_mag(w_b_ext, w_b_neg);
    assign w_min   = bus.word ? {{(XLEN-DIV_WLEN+1){1'b1}}, {(DIV_WLEN-1){1'b0}}}
                              : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div0  = (w_b_ext == '0);
    assign w_ovf   = bus.is_signed && (w_a_ext == w_min) && (w_b_ext == '1);
`ifdef DIV_EARLY_OUT_EN
    assign w_early = !w_div0 && (w_a_mag < w_b_mag);
`else
    assign w_early = 1'b0;
`endif

    // Special-case results are staged with identity fixup so they share the RUN exit.
    assign w_q_fix = div_ext(div_mag(r_q,   r_qneg), r_word ? DIV_WLEN : XLEN, 1'b1);
    assign w_r_fix = div_ext(div_mag(r_acc, r_rneg), r_word ? DIV_WLEN : XLEN, 1'b1);

    div_step #(.XLEN(XLEN)) u_step (
        .i_rem  (r_acc),
        .i_qin  (r_q[XLEN-1]),
        .i_div  (r_d),
        .o_rem  (w_step_rem),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_d       <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_word    <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_data_ok <= 1'b0;
        end else begin
            r_data_ok <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.valid) begin
                        r_state <= RUN;
                        r_d     <= w_b_mag;
                        if (w_div0 || w_ovf || w_early) begin
                            r_cnt  <= '0;
                            r_qneg <= 1'b0;
                            r_rneg <= 1'b0;
                            r_word <= 1'b0;
                            r_q    <= w_div0 ? '1 : (w_ovf ? w_a_res : '0);
                            r_acc  <= w_ovf ? '0 : w_a_res;
                        end else begin
                            r_cnt  <= CW'(w_width);
                            r_qneg <= w_a_neg ^ w_b_neg;
                            r_rneg <= w_a_neg;
                            r_word <= bus.word;
                            r_acc  <= '0;
                            // Word dividend is left-aligned so its MSB is shifted out first.
                            r_q    <= bus.word ? {w_a_mag[DIV_WLEN-1:0], {(XLEN-DIV_WLEN){1'b0}}}
                                               : w_a_mag;
                        end
                    end
                end
                RUN: begin
                    if (!bus.valid) begin
                        r_state <= IDLE;
                    end else if (r_cnt == '0) begin
                        r_quot    <= w_q_fix;
                        r_rem     <= w_r_fix;
                        r_data_ok <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_acc <= w_step_rem;
                        r_q   <= {r_q[XLEN-2:0], w_qbit};
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.quot    = r_quot;
    assign bus.rem     = r_rem;
    assign bus.data_ok = r_data_ok;
endmodule

`default_nettype wire

// File: tb/tb_iter_divider.sv
//==============================================================================
// Module      : tb_iter_divider
// Description : Directed self-checking bench for iter_divider.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_iter_divider;
    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    iter_divider_if #(.XLEN(64)) bus ();

    iter_divider #(.XLEN(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drives a request at a negedge, E0 is the following posedge; k=0 is the cycle after E0.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic sgn, input logic wd,
                          input logic [63:0] eq, input logic [63:0] er,
                          input int lat, input bit scramble);
        int seen;
        logic [63:0] q_obs, r_obs;
        seen  = -1;
        q_obs = 'x;
        r_obs = 'x;
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = sgn;
        bus.word      = wd;
        bus.valid     = 1'b1;
        for (int k = 0; k <= lat + 5; k++) begin
            @(negedge clk);
            if (scramble && k == 2) begin
                bus.a = {$urandom(), $urandom()};
                bus.b = {$urandom(), $urandom()};
            end
            if (bus.data_ok === 1'b1) begin
                seen  = k;
                q_obs = bus.quot;
                r_obs = bus.rem;
                break;
            end
        end
        bus.valid = 1'b0;
        chk({tag, "_lat"}, 64'(seen), 64'(lat));
        chk({tag, "_quot"}, q_obs, eq);
        chk({tag, "_rem"}, r_obs, er);
        @(negedge clk);
        chk({tag, "_width"}, {63'd0, bus.data_ok}, 64'd0);
    endtask

    initial begin
        logic seen_ok;
        n_total       = 0;
        n_pass        = 0;
        reset         = 1'b1;
        bus.valid     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.is_signed = 1'b0;
        bus.word      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_quot", bus.quot, 64'd0);
        chk("reset_rem", bus.rem, 64'd0);
        chk("reset_ok", {63'd0, bus.data_ok}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("s64_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b1);
        run_op("s64_7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65, 1'b0);
        run_op("u64_max_16", 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b0,
               64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 65, 1'b0);
        run_op("div0_s64", 64'd5, 64'd0, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1, 1'b0);
        run_op("div0_w", 64'h1_8000_0001, 64'h5_0000_0000, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1, 1'b0);
        run_op("ovf_s64", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               64'h8000_0000_0000_0000, 64'd0, 1, 1'b0);
        run_op("ovf_w", 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1,
               64'hFFFF_FFFF_8000_0000, 64'd0, 1, 1'b0);
        run_op("wu_7_2", 64'h1_0000_0007, 64'd2, 1'b0, 1'b1,
               64'd3, 64'd1, 33, 1'b0);
        run_op("ws_m7_2", 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_0000_0000_0002, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b0);
        run_op("wu_max_1", 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33, 1'b0);
`ifdef DIV_EARLY_OUT_EN
        run_op("small_3_10", 64'd3, 64'd10, 1'b0, 1'b0, 64'd0, 64'd3, 1, 1'b0);
`else
        run_op("small_3_10", 64'd3, 64'd10, 1'b0, 1'b0, 64'd0, 64'd3, 65, 1'b0);
`endif

        // Abort after 10 RUN cycles, then an immediate new request.
        seen_ok       = 1'b0;
        bus.a         = 64'd100;
        bus.b         = 64'd7;
        bus.is_signed = 1'b0;
        bus.word      = 1'b0;
        bus.valid     = 1'b1;
        repeat (11) begin
            @(negedge clk);
            seen_ok = seen_ok | (bus.data_ok !== 1'b0);
        end
        bus.valid = 1'b0;
        @(negedge clk);
        seen_ok = seen_ok | (bus.data_ok !== 1'b0);
        chk("abort_no_ok", {63'd0, seen_ok}, 64'd0);
        run_op("after_abort", 64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 64'd0, 65, 1'b0);

        // Asynchronous reset in the middle of RUN.
        bus.a     = 64'd1000;
        bus.b     = 64'd3;
        bus.valid = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_quot", bus.quot, 64'd0);
        chk("midrst_rem", bus.rem, 64'd0);
        chk("midrst_ok", {63'd0, bus.data_ok}, 64'd0);
        bus.valid = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        seen_ok = 1'b0;
        repeat (70) begin
            @(negedge clk);
            seen_ok = seen_ok | (bus.data_ok !== 1'b0);
        end
        chk("midrst_no_ok", {63'd0, seen_ok}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
